wbi_master_port_m0: RTL
=======================

# wbi_master_port_m0

Master-side entry port of the daisy-chained Wishbone interconnect. It converts a native Wishbone burst master (cyc/stb/ack/lack/bry) into the valid/ready command channel that feeds the first slave port of the chain. It also collects the tagged responses coming back on the response channel. Each instance owns one transaction ID (MID); transactions are non-posted and one transaction is outstanding at a time.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- BW, 4, byte-enable width
- BL, 10, burst-length width
- MID, 4'h0, transaction ID driven on `wbp_cmd_tid_o` and expected on `wbp_res_tid_i`
- TMO, 1023, response timeout in cycles (used only with the macro in Configuration)

Ports:
- mclk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wbm_cyc_i / wbm_stb_i  in  1  master cycle / strobe
- wbm_adr_i  in  AW  address
- wbm_we_i  in  1  write
- wbm_dat_i  in  DW  write data
- wbm_sel_i  in  BW  byte enable
- wbm_bl_i  in  BL  burst length (0 is treated as 1)
- wbm_bry_i  in  1  write: beat data valid; read: ready to take read data
- wbm_dat_o  out  DW  read data
- wbm_ack_o / wbm_lack_o / wbm_err_o  out  1  beat ack / last ack / error
- wbp_cmd_wrdy_i  in  1  chain ready
- wbp_cmd_wval_o  out  1  command valid
- wbp_cmd_adr_o, _we_o, _dat_o, _sel_o, _tid_o(4), _bl_o  out  command fields
- wbp_res_rrdy_o  out  1  ready for a response
- wbp_res_rval_i, _dat_i, _ack_i, _lack_i, _err_i, _tid_i(4)  in  response fields
- tid_err_o  out  1  sticky flag: a response arrived with the wrong TID

## Operation
- States: IDLE, RCMD, WCMD, RESP.
- IDLE: on `cyc&stb`, latch adr/we/bl/sel/dat. `beats` = max(bl,1). Go to WCMD if we, else RCMD.
- RCMD: send one command carrying the full bl. On `wval&wrdy`, go to RESP.
- WCMD: one command beat per data beat; adr and bl stay constant, dat and sel change per beat.
  - Capture the next beat when the output stage is empty, `wbm_bry_i`=1 and no ack is pending.
  - Non-last beats: pulse `wbm_ack_o` when the beat is captured.
  - Last beat: on its handshake, go to RESP.
- RESP: `wbp_res_rrdy_o` = `wbm_bry_i`. Each accepted response with `tid==MID` is registered to wbm_dat/ack/lack/err.
  - Reads: `lack_i` ends the transaction and returns to IDLE.
  - Writes: a single response with `lack` ends the transaction.
  - `err_i` ends the transaction immediately with `wbm_err_o`=1 and `wbm_lack_o`=1.
- A response with `tid!=MID` is accepted and dropped, and sets `tid_err_o`. Only reset clears it.
- Dropping `cyc` mid-transaction has no effect: the port finishes the chain side and discards responses.

## Timing
- Reset values: all outputs 0. `wbp_cmd_tid_o`=MID. State is IDLE.
- Command outputs are registered. `stb` sampled in IDLE at cycle N gives `wbp_cmd_wval_o`=1 at N+1.
- `wval` stays high with all fields stable until `wrdy`. Fields never change while `wval&!wrdy`.
- Response `rval&rrdy` at cycle M gives a 1-cycle `wbm_ack_o` pulse at M+1.
- Read burst at full rate: one ack per cycle.
- `wbm_ack_o` is a single-cycle pulse. `wbm_lack_o` and `wbm_err_o` are valid only with `wbm_ack_o`.
- Write-beat ack is registered: capture at cycle K gives ack at K+1. No capture is allowed while the ack is pending, so the maximum write rate is one beat per 2 cycles.
- `beats` is a BL-bit down counter. It does not wrap: bl=2^BL−1 is legal.
- Reset asserted mid-transaction returns the port to IDLE immediately. Any outstanding responses are not tracked.

## Configuration
- WBI_MPORT_TIMEOUT_EN defined:
  - A TMO-cycle counter runs in RCMD, WCMD and RESP. It reloads on every command or response handshake.
  - On expiry, the port pulses `wbm_ack_o`+`wbm_err_o`+`wbm_lack_o` and goes to IDLE.
  - Late responses for the abandoned transaction are then dropped.
- WBI_MPORT_TIMEOUT_EN undefined: no counter; the port waits forever.

## Test plan
- Single read, adr=0x1000_0040, bl=1, wrdy=1, response dat=0xA5A5_1234 with lack after 3 cycles -> `wval_o` 1 cycle after stb; one `wbm_ack_o`+`lack_o` with dat 0xA5A5_1234.
- Read burst bl=4, bry=1 -> 4 consecutive acks, `lack_o` only on the 4th; then `wbm_bry_i`=0 for 2 cycles mid-burst -> `rrdy_o`=0 and no ack during those cycles.
- Write burst bl=3, wrdy toggling 1/0 -> 3 command beats with constant adr/bl/tid and fields stable while stalled; 2 beat acks, then a final ack+lack on the response.
- Response with err_i=1 on beat 2 of bl=4 read -> ack+err+lack on that beat, state IDLE, next transaction accepted.
- Response with tid=MID^1 -> dropped, no `wbm_ack_o`, `tid_err_o`=1 until reset.
- With WBI_MPORT_TIMEOUT_EN and TMO=15, no response -> ack+err+lack exactly 15 cycles after the command handshake; a late response is dropped. Async reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/wbi_master_port_m0.sv
`timescale 1ns/1ps
// Master-side entry port: native Wishbone burst master -> chain command channel, tagged responses back.
// Optional response timeout is compiled in when WBI_MPORT_TIMEOUT_EN is defined.
module wbi_master_port_m0 #(
   parameter int         AW  = 32,
   parameter int         DW  = 32,
   parameter int         BW  = 4,
   parameter int         BL  = 10,
   parameter logic [3:0] MID = 4'h0,
   parameter int         TMO = 1023
) (
   input  logic          mclk,
   input  logic          reset,
   input  logic          wbm_cyc_i,
   input  logic          wbm_stb_i,
   input  logic [AW-1:0] wbm_adr_i,
   input  logic          wbm_we_i,
   input  logic [DW-1:0] wbm_dat_i,
   input  logic [BW-1:0] wbm_sel_i,
   input  logic [BL-1:0] wbm_bl_i,
   input  logic          wbm_bry_i,
   output logic [DW-1:0] wbm_dat_o,
   output logic          wbm_ack_o,
   output logic          wbm_lack_o,
   output logic          wbm_err_o,
   input  logic          wbp_cmd_wrdy_i,
   output logic          wbp_cmd_wval_o,
   output logic [AW-1:0] wbp_cmd_adr_o,
   output logic          wbp_cmd_we_o,
   output logic [DW-1:0] wbp_cmd_dat_o,
   output logic [BW-1:0] wbp_cmd_sel_o,
   output logic [3:0]    wbp_cmd_tid_o,
   output logic [BL-1:0] wbp_cmd_bl_o,
   output logic          wbp_res_rrdy_o,
   input  logic          wbp_res_rval_i,
   input  logic [DW-1:0] wbp_res_dat_i,
   input  logic          wbp_res_ack_i,
   input  logic          wbp_res_lack_i,
   input  logic          wbp_res_err_i,
   input  logic [3:0]    wbp_res_tid_i,
   output logic          tid_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_RCMD, S_WCMD, S_RESP} state_t;

   state_t        r_state;
   logic [BL-1:0] r_beats;
   logic          r_pend;
   logic [BL-1:0] w_bl1;
   logic          w_cmd_hs;
   logic          w_res_hs;
   logic          w_tid_ok;
   logic          w_res_end;
   logic          w_cap;
   logic          w_drain;
   logic          w_tmo_fire;

   assign wbp_cmd_tid_o  = MID;
   assign w_bl1          = (wbm_bl_i == '0) ? BL'(1) : wbm_bl_i;
   assign w_cmd_hs       = wbp_cmd_wval_o & wbp_cmd_wrdy_i;
   // Once the master drops cyc the port keeps draining the chain on its own.
   assign wbp_res_rrdy_o = ((r_state == S_RESP) & (wbm_bry_i | ~wbm_cyc_i)) | w_drain;
   assign w_res_hs       = wbp_res_rval_i & wbp_res_rrdy_o;
   assign w_tid_ok       = (wbp_res_tid_i == MID);
   assign w_res_end      = wbp_res_lack_i | wbp_res_err_i;
   // r_pend blocks a capture in the cycle the previous beat's ack is shown.
   assign w_cap = (r_state == S_WCMD) & (r_beats != '0) & ~r_pend
                & (~wbp_cmd_wval_o | wbp_cmd_wrdy_i) & (wbm_bry_i | ~wbm_cyc_i);

`ifdef WBI_MPORT_TIMEOUT_EN
   localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

   logic [TW-1:0] r_tmo;
   logic          r_drain;

   assign w_drain    = r_drain;
   assign w_tmo_fire = (r_state != S_IDLE) & (r_tmo == '0) & ~w_cmd_hs & ~w_res_hs;

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         r_tmo   <= '0;
         r_drain <= 1'b0;
      end else begin
         if (r_state == S_IDLE || w_cmd_hs || w_res_hs)
            r_tmo <= TW'(TMO - 1);
         else if (r_tmo != '0)
            r_tmo <= r_tmo - 1'b1;
         // After an expiry, late responses of the abandoned transaction are swallowed.
         if (w_tmo_fire)
            r_drain <= 1'b1;
         else if (w_cmd_hs || (r_drain && w_res_hs && w_res_end))
            r_drain <= 1'b0;
      end
   end
`else
   assign w_drain    = 1'b0;
   assign w_tmo_fire = 1'b0;
`endif

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_beats        <= '0;
         r_pend         <= 1'b0;
         wbp_cmd_wval_o <= 1'b0;
         wbp_cmd_adr_o  <= '0;
         wbp_cmd_we_o   <= 1'b0;
         wbp_cmd_dat_o  <= '0;
         wbp_cmd_sel_o  <= '0;
         wbp_cmd_bl_o   <= '0;
         wbm_dat_o      <= '0;
         wbm_ack_o      <= 1'b0;
         wbm_lack_o     <= 1'b0;
         wbm_err_o      <= 1'b0;
         tid_err_o      <= 1'b0;
      end else begin
         wbm_ack_o  <= 1'b0;
         wbm_lack_o <= 1'b0;
         wbm_err_o  <= 1'b0;
         r_pend     <= 1'b0;
         if (w_res_hs && !w_tid_ok)
            tid_err_o <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (wbm_cyc_i && wbm_stb_i) begin
                  wbp_cmd_wval_o <= 1'b1;
                  wbp_cmd_adr_o  <= wbm_adr_i;
                  wbp_cmd_we_o   <= wbm_we_i;
                  wbp_cmd_dat_o  <= wbm_dat_i;
                  wbp_cmd_sel_o  <= wbm_sel_i;
                  wbp_cmd_bl_o   <= wbm_bl_i;
                  r_beats        <= w_bl1 - 1'b1;
                  r_pend         <= 1'b1;
                  wbm_ack_o      <= wbm_we_i & (w_bl1 != BL'(1));
                  r_state        <= wbm_we_i ? S_WCMD : S_RCMD;
               end
            end
            S_RCMD: begin
               if (w_cmd_hs) begin
                  wbp_cmd_wval_o <= 1'b0;
                  r_state        <= S_RESP;
               end
            end
            S_WCMD: begin
               if (w_cap) begin
                  wbp_cmd_wval_o <= 1'b1;
                  wbp_cmd_dat_o  <= wbm_dat_i;
                  wbp_cmd_sel_o  <= wbm_sel_i;
                  r_beats        <= r_beats - 1'b1;
                  r_pend         <= 1'b1;
                  wbm_ack_o      <= wbm_cyc_i & (r_beats != BL'(1));
               end else if (w_cmd_hs) begin
                  wbp_cmd_wval_o <= 1'b0;
                  if (r_beats == '0)
                     r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (w_res_hs && w_tid_ok) begin
                  if (wbm_cyc_i) begin
                     wbm_dat_o  <= wbp_res_dat_i;
                     wbm_ack_o  <= wbp_res_ack_i | w_res_end;
                     wbm_lack_o <= w_res_end;
                     wbm_err_o  <= wbp_res_err_i;
                  end
                  if (w_res_end)
                     r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_tmo_fire) begin
            wbm_ack_o      <= 1'b1;
            wbm_lack_o     <= 1'b1;
            wbm_err_o      <= 1'b1;
            wbp_cmd_wval_o <= 1'b0;
            r_state        <= S_IDLE;
         end
      end
   end

endmodule
